sig_period_meter: RTL and testbench

- Measures the period and high time of a slow, asynchronous square wave, such as an odd-ratio divided clock, using a faster system clock `clk`.
- Sits directly downstream of the team's clock-divider blocks as the on-chip checker of their output.
- Reports each completed period with a one-cycle valid strobe.
- Flags loss of signal with a saturating timeout.

---
 rtl/sig_period_meter.sv | 156 +++++++++++++++
 tb/tb_sig_period_meter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sig_period_meter.sv
// Period and high-time meter for a slow asynchronous square wave, with a sticky loss-of-signal timeout.
// Define DUTY_MEAS_EN to build the high-time counter; without it high_time reads as 0.
module sig_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lvl_prev_q, lvl_prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;

    logic lvl;
    logic rise;
    logic take_rise;
    logic capture;
    logic clr;

    assign sync_d     = {sync_q[SYNC_STAGES-2:0], sig_in};
    assign lvl        = sync_q[SYNC_STAGES-1];
    assign lvl_prev_d = lvl;
    assign rise       = lvl & ~lvl_prev_q;

    // A dropped enable overrides everything, including a rise in the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        take_rise = 1'b0;
        capture   = 1'b0;
        clr       = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            clr     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    clr     = 1'b1;
                    state_d = ARM;
                end
                ARM, MEASURE: begin
                    if (rise) begin
                        take_rise = 1'b1;
                        capture   = (state_q == MEASURE);
                        state_d   = MEASURE;
                    end else if (cnt_q == {CNT_W{1'b1}}) begin
                        timeout_d = 1'b1;
                        clr       = 1'b1;
                        state_d   = ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    clr     = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end

        if (clr) begin
            cnt_d = '0;
        end else if (take_rise) begin
            cnt_d = CNT_W'(1);
        end

        if (capture) begin
            period_d  = cnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            lvl_prev_q <= 1'b0;
            cnt_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            lvl_prev_q <= lvl_prev_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef DUTY_MEAS_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_q, high_d;

    // hcnt never exceeds cnt, so it shares the reload/clear events and needs no own saturation.
    always_comb begin
        hcnt_d = hcnt_q;
        high_d = high_q;
        if (clr) begin
            hcnt_d = '0;
        end else if (take_rise) begin
            hcnt_d = CNT_W'(1);
            if (capture) begin
                high_d = hcnt_q;
            end
        end else if (state_q == MEASURE && lvl) begin
            hcnt_d = hcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            high_q <= high_d;
        end
    end

    assign high_time = high_q;
`else
    assign high_time = '0;
`endif

    assign period     = period_q;
    assign meas_valid = valid_q;
    assign timeout    = timeout_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sig_period_meter.sv
// Directed bench for sig_period_meter: a 16-bit instance for measurement checks and a
// 4-bit instance sharing the same stimulus for the timeout checks.
module tb_sig_period_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig_in;
    logic        enable;

    logic [15:0] period16, high16;
    logic        valid16, timeout16, busy16;
    logic [3:0]  period4, high4;
    logic        valid4, timeout4, busy4;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    int q16_per[$];
    int q16_high[$];
    int q16_cyc[$];
    int q4_per[$];
    int q4_to[$];
    int q4_prev_to[$];
    int rise_q[$];
    int valid16_cnt = 0;
    logic prev_to4 = 1'b0;

    sig_period_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut16 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable),
        .period(period16), .high_time(high16), .meas_valid(valid16),
        .timeout(timeout16), .busy(busy16)
    );

    sig_period_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable),
        .period(period4), .high_time(high4), .meas_valid(valid4),
        .timeout(timeout4), .busy(busy4)
    );

    always #5 clk = ~clk;

    // cyc numbers the posedges; a value driven at a negedge is sampled at edge cyc+1.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every report shortly after the edge that produced it.
    always @(posedge clk) begin
        #2;
        if (valid16 === 1'b1) begin
            q16_per.push_back(int'(period16));
            q16_high.push_back(int'(high16));
            q16_cyc.push_back(cyc);
            valid16_cnt++;
        end
        if (valid4 === 1'b1) begin
            q4_per.push_back(int'(period4));
            q4_to.push_back(int'(timeout4));
            q4_prev_to.push_back(int'(prev_to4));
        end
        prev_to4 = timeout4;
    end

    function automatic int exp_h(input int h);
`ifdef DUTY_MEAS_EN
        return h;
`else
        return 0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at a negedge and return at the following negedge.
    task automatic applyStimulus(input logic s, input logic en, input logic r);
        sig_in = s;
        enable = en;
        rst    = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic runWave(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < p; j++) begin
                if (j == 0) rise_q.push_back(cyc + 1);
                applyStimulus(j < h, 1'b1, 1'b0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_per[7];
        int exp_hi[7];
        int s_last;
        int to_cyc;
        int v_before;
        logic busy_seen;

        sig_in = 1'b0;
        enable = 1'b0;
        rst    = 1'b1;

        // Reset with sig_in toggling.
        for (int i = 0; i < 3; i++) applyStimulus(i[0], 1'b0, 1'b1);
        checkOutput("rst_period", period16, 0);
        checkOutput("rst_high", high16, 0);
        checkOutput("rst_valid", valid16, 0);
        checkOutput("rst_timeout", timeout16, 0);
        checkOutput("rst_busy", busy16, 0);
        checkOutput("rst_busy4", busy4, 0);

        // Idle with enable low: no reports, never busy.
        v_before  = valid16_cnt;
        busy_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(i[1], 1'b0, 1'b0);
            busy_seen |= busy16;
        end
        checkOutput("idle_valid_count", valid16_cnt - v_before, 0);
        checkOutput("idle_busy", busy_seen, 0);

        // Period 6 / high 3.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("arm_busy", busy16, 1);
        rise_q.delete();
        q16_per.delete(); q16_high.delete(); q16_cyc.delete();
        runWave(6, 3, 6);
        checkOutput("p6_count", q16_per.size(), 5);
        if (q16_cyc.size() > 0)
            checkOutput("p6_first_latency", q16_cyc[0], rise_q[1] + 2);
        for (int i = 0; i < q16_per.size(); i++) begin
            checkOutput("p6_period", q16_per[i], 6);
            checkOutput("p6_high", q16_high[i], exp_h(3));
            if (i > 0) checkOutput("p6_spacing", q16_cyc[i] - q16_cyc[i-1], 6);
        end

        // Period 9 / high 5 then period 4 / high 2, back to back.
        exp_per = '{6, 9, 9, 9, 4, 4, 4};
        exp_hi  = '{3, 5, 5, 5, 2, 2, 2};
        q16_per.delete(); q16_high.delete(); q16_cyc.delete();
        runWave(9, 5, 3);
        runWave(4, 2, 4);
        checkOutput("mix_count", q16_per.size(), 7);
        for (int i = 0; i < q16_per.size() && i < 7; i++) begin
            checkOutput("mix_period", q16_per[i], exp_per[i]);
            checkOutput("mix_high", q16_high[i], exp_h(exp_hi[i]));
        end

        // Loss of signal on the 4-bit instance: reload at s+2, cnt hits 15 at s+16, flag at s+17.
        s_last = rise_q[rise_q.size()-1];
        to_cyc = -1;
        q4_per.delete(); q4_to.delete(); q4_prev_to.delete();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (timeout4 === 1'b1 && to_cyc < 0) to_cyc = cyc;
        end
        checkOutput("to_cycle", to_cyc, s_last + 17);
        checkOutput("to_flag", timeout4, 1);
        checkOutput("to_period_hold", period4, 4);
        checkOutput("to_high_hold", high4, exp_h(2));
        checkOutput("to_busy_arm", busy4, 1);
        checkOutput("to_no_report", q4_per.size(), 0);
        checkOutput("to_wide_no_timeout", timeout16, 0);

        // Restart: timeout clears with the first new report.
        runWave(6, 3, 3);
        checkOutput("restart_count", q4_per.size(), 2);
        if (q4_per.size() > 0) begin
            checkOutput("restart_period", q4_per[0], 6);
            checkOutput("restart_to_at_report", q4_to[0], 0);
            checkOutput("restart_to_before", q4_prev_to[0], 1);
        end

        // enable dropped in the cycle the rise is seen.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        q16_per.delete(); q16_high.delete(); q16_cyc.delete();
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("drop_busy", busy16, 0);
        checkOutput("drop_period_hold", period16, 6);
        checkOutput("drop_high_hold", high16, exp_h(3));
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("drop_no_report", q16_per.size(), 0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("reenable_busy", busy16, 1);
        rise_q.delete();
        runWave(7, 3, 3);
        checkOutput("reenable_count", q16_per.size(), 2);
        if (q16_per.size() > 0) begin
            checkOutput("reenable_period", q16_per[0], 7);
            checkOutput("reenable_high", q16_high[0], exp_h(3));
            checkOutput("reenable_latency", q16_cyc[0], rise_q[1] + 2);
        end

        // Reset in the middle of a measured period.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("midrst_period", period16, 0);
        checkOutput("midrst_high", high16, 0);
        checkOutput("midrst_valid", valid16, 0);
        checkOutput("midrst_timeout", timeout16, 0);
        checkOutput("midrst_busy", busy16, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        q16_per.delete(); q16_high.delete(); q16_cyc.delete();
        rise_q.delete();
        runWave(8, 4, 3);
        checkOutput("midrst_count", q16_per.size(), 2);
        if (q16_per.size() > 0) begin
            checkOutput("midrst_first_period", q16_per[0], 8);
            checkOutput("midrst_first_high", q16_high[0], exp_h(4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
